video_timing_generator: RTL and testbench

//   Master Apple II/e video timing chain running off the 14.31818 MHz clock.

---
 rtl/video_timing_generator.sv | 132 +++++++++++++
 tb/tb_video_timing_generator.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_generator.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_generator
// Description : Apple II/e master video timing chain on the 14.31818 MHz clock:
//               CPU phase, dot clock, H/V counters, blanking, sync and flash.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_generator #(
    parameter logic [6:0] H_VIS_START = 7'h58,
    parameter logic [6:0] HS_START    = 7'h48,
    parameter logic [8:0] VS_START    = 9'h1E0,
    parameter int         FLASH_DIV   = 16
) (
    input  logic       CLK_14M,
    input  logic       reset,
    output logic       CLK_7M,
    output logic       PHI0,
    output logic       CPU_EN,
    output logic       LDPS_N,
    output logic [6:0] H,
    output logic [8:0] V,
    output logic       SEGA,
    output logic       SEGB,
    output logic       SEGC,
    output logic       HBL,
    output logic       VBL,
    output logic       WNDW_N,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       FLASH_CLK
);

    localparam int               c_F_W         = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [c_F_W-1:0] c_F_LAST      = c_F_W'(FLASH_DIV - 1);
    localparam logic [3:0]       c_P_LAST      = 4'd13;
    localparam logic [3:0]       c_P_LAST_LONG = 4'd15;
    localparam logic [6:0]       c_H_LONG      = 7'h40;
    localparam logic [6:0]       c_H_LAST      = 7'h7F;
    localparam logic [8:0]       c_V_FIRST     = 9'h0FA;
    localparam logic [8:0]       c_V_LAST      = 9'h1FF;
    localparam logic [8:0]       c_V_VIS_START = 9'h100;
    localparam logic [8:0]       c_V_VIS_END   = 9'h1C0;

    logic [3:0]       p_q,     p_d;
    logic [6:0]       h_q,     h_d;
    logic [8:0]       v_q,     v_d;
    logic [c_F_W-1:0] f_q,     f_d;
    logic             flash_q, flash_d;

    logic w_long;
    logic w_cyc_end;
    logic w_line_end;
    logic w_frame_end;
    logic w_hbl;
    logic w_vbl;

    // The H=0x40 cycle is stretched by two clocks to make the line 912 clocks.
    always_comb begin
        w_long      = (h_q == c_H_LONG);
        w_cyc_end   = (p_q == (w_long ? c_P_LAST_LONG : c_P_LAST));
        w_line_end  = w_cyc_end && (h_q == c_H_LAST);
        w_frame_end = w_line_end && (v_q == c_V_LAST);

        p_d = w_cyc_end ? 4'd0 : p_q + 4'd1;

        h_d = h_q;
        if (w_cyc_end) begin
            if (h_q == 7'h00) begin
                h_d = c_H_LONG;
            end else if (h_q == c_H_LAST) begin
                h_d = 7'h00;
            end else begin
                h_d = h_q + 7'd1;
            end
        end

        v_d = v_q;
        if (w_line_end) begin
            v_d = (v_q == c_V_LAST) ? c_V_FIRST : v_q + 9'd1;
        end

        f_d     = f_q;
        flash_d = flash_q;
        if (w_frame_end) begin
            if (f_q == c_F_LAST) begin
                f_d     = '0;
                flash_d = ~flash_q;
            end else begin
                f_d = f_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_14M) begin
        if (reset) begin
            p_q     <= 4'd0;
            h_q     <= 7'h00;
            v_q     <= c_V_FIRST;
            f_q     <= '0;
            flash_q <= 1'b0;
        end else begin
            p_q     <= p_d;
            h_q     <= h_d;
            v_q     <= v_d;
            f_q     <= f_d;
            flash_q <= flash_d;
        end
    end

    // Decodes come straight from the counter flops so they move in the same clock as H/V.
    always_comb begin
        w_hbl     = (h_q < H_VIS_START);
        w_vbl     = (v_q < c_V_VIS_START) || (v_q >= c_V_VIS_END);
        CLK_7M    = p_q[0];
        PHI0      = (p_q >= 4'd7);
        CPU_EN    = w_cyc_end;
        LDPS_N    = !((p_q == 4'd12) || (p_q == 4'd13));
        H         = h_q;
        V         = v_q;
        SEGA      = v_q[0];
        SEGB      = v_q[1];
        SEGC      = v_q[2];
        HBL       = w_hbl;
        VBL       = w_vbl;
        WNDW_N    = w_hbl || w_vbl;
        HSYNC     = (h_q >= HS_START) && (h_q < HS_START + 7'd4);
        VSYNC     = (v_q >= VS_START) && (v_q < VS_START + 9'd4);
        FLASH_CLK = flash_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing_generator
// Description : Self-checking bench; reference timing derived from the clock
//               count since reset using plain line/frame arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_generator;

    localparam int    FDIV  = 2;
    localparam longint LINE  = 912;
    localparam longint FRAME = 262 * 912;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       CLK_7M, PHI0, CPU_EN, LDPS_N;
    logic [6:0] H;
    logic [8:0] V;
    logic       SEGA, SEGB, SEGC, HBL, VBL, WNDW_N, HSYNC, VSYNC, FLASH_CLK;
    logic [28:0] dut_bus;

    int     checks = 0;
    int     errors = 0;
    longint n = 0;

    video_timing_generator #(
        .H_VIS_START (7'h58),
        .HS_START    (7'h48),
        .VS_START    (9'h1E0),
        .FLASH_DIV   (FDIV)
    ) dut (
        .CLK_14M   (clk),
        .reset     (reset),
        .CLK_7M    (CLK_7M),
        .PHI0      (PHI0),
        .CPU_EN    (CPU_EN),
        .LDPS_N    (LDPS_N),
        .H         (H),
        .V         (V),
        .SEGA      (SEGA),
        .SEGB      (SEGB),
        .SEGC      (SEGC),
        .HBL       (HBL),
        .VBL       (VBL),
        .WNDW_N    (WNDW_N),
        .HSYNC     (HSYNC),
        .VSYNC     (VSYNC),
        .FLASH_CLK (FLASH_CLK)
    );

    always #5 clk = ~clk;

    assign dut_bus = {CLK_7M, PHI0, CPU_EN, LDPS_N, H, V, SEGA, SEGB, SEGC,
                      HBL, VBL, WNDW_N, HSYNC, VSYNC, FLASH_CLK};

    // Expected outputs t clocks after the reset edge.
    function automatic logic [28:0] model(input longint t);
        longint     fr, r, o;
        int         h, p, last, v;
        logic [8:0] vv;
        logic       c7, phi, cpu, ld, hbl, vbl, hs, vs, fl;
        fr = t / FRAME;
        r  = t % FRAME;
        v  = 250 + int'(r / LINE);
        o  = r % LINE;
        if (o < 14) begin
            h = 0;  p = int'(o);      last = 13;
        end else if (o < 30) begin
            h = 64; p = int'(o) - 14; last = 15;
        end else begin
            h = 65 + int'((o - 30) / 14); p = int'((o - 30) % 14); last = 13;
        end
        vv  = 9'(v);
        c7  = (p % 2) == 1;
        phi = (p >= 7);
        cpu = (p == last);
        ld  = !(p == 12 || p == 13);
        hbl = (h < 88);
        vbl = (v < 256) || (v >= 448);
        hs  = (h >= 72) && (h < 76);
        vs  = (v >= 480) && (v < 484);
        fl  = ((fr / FDIV) % 2) == 1;
        return {c7, phi, cpu, ld, 7'(h), vv, vv[0], vv[1], vv[2],
                hbl, vbl, hbl || vbl, hs, vs, fl};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n = 0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if (dut_bus !== model(0)) begin
            $display("FAIL reset_outputs got %h expected %h", dut_bus, model(0));
            errors++;
        end
        checks++;
        if ({H, V, FLASH_CLK} !== {7'h00, 9'h0FA, 1'b0}) begin
            $display("FAIL reset_hv got H=%h V=%h F=%b expected H=00 V=0fa F=0", H, V, FLASH_CLK);
            errors++;
        end
    endtask

    task automatic test_line_timing;
        int         len, dot, lo, pulses;
        logic       bad, done;
        logic [6:0] prev_h;
        do_reset;
        bad = 0; done = 0; len = 0; dot = 0; lo = 0; pulses = 0; prev_h = H;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (!bad) begin
                checks++;
                if (dut_bus !== model(n)) begin
                    $display("FAIL line_model n=%0d got %h expected %h", n, dut_bus, model(n));
                    errors++; bad = 1;
                end
            end
            len++;
            if (!CLK_7M && !LDPS_N) dot++;
            if (!CLK_7M) lo++;
            if (CPU_EN) begin
                checks++;
                if (len !== ((pulses == 1) ? 16 : 14)) begin
                    $display("FAIL cycle_len idx=%0d got %0d expected %0d", pulses, len, (pulses == 1) ? 16 : 14);
                    errors++;
                end
                checks++;
                if (dot !== 1) begin
                    $display("FAIL dot_load idx=%0d got %0d expected 1", pulses, dot);
                    errors++;
                end
                checks++;
                if (lo !== ((pulses == 1) ? 8 : 7)) begin
                    $display("FAIL clk7_low idx=%0d got %0d expected %0d", pulses, lo, (pulses == 1) ? 8 : 7);
                    errors++;
                end
                pulses++; len = 0; dot = 0; lo = 0;
            end
            tick;
            if (H == 7'h00 && prev_h == 7'h7F) done = 1;
            prev_h = H;
        end
        checks++;
        if (n !== LINE) begin
            $display("FAIL line_clocks got %0d expected %0d", n, LINE);
            errors++;
        end
        checks++;
        if (pulses !== 65) begin
            $display("FAIL cpu_en_pulses got %0d expected 65", pulses);
            errors++;
        end
    endtask

    // Runs from the current reset point until H wraps and checks the line length.
    task automatic test_random_reset;
        int         k;
        logic       bad, done;
        logic [6:0] prev_h;
        for (int it = 0; it < 3; it++) begin
            k = $urandom_range(6000, 50);
            do_reset;
            bad = 0;
            for (int i = 0; i < k; i++) begin
                tick;
                if (!bad) begin
                    checks++;
                    if (dut_bus !== model(n)) begin
                        $display("FAIL rnd_model n=%0d got %h expected %h", n, dut_bus, model(n));
                        errors++; bad = 1;
                    end
                end
            end
            do_reset;
            checks++;
            if (dut_bus !== model(0)) begin
                $display("FAIL rnd_reset k=%0d got %h expected %h", k, dut_bus, model(0));
                errors++;
            end
            done = 0; prev_h = H;
            for (int i = 0; i < 2000 && !done; i++) begin
                tick;
                if (H == 7'h00 && prev_h == 7'h7F) done = 1;
                prev_h = H;
            end
            checks++;
            if (n !== LINE) begin
                $display("FAIL rnd_realign got %0d expected %0d", n, LINE);
                errors++;
            end
        end
    endtask

    task automatic test_midframe_reset;
        longint     target;
        logic       bad, done;
        logic [6:0] prev_h;
        target = (9'h150 - 250) * LINE + 30 + (7'h63 - 65) * 14 + 9;
        do_reset;
        bad = 0;
        while (n < target) begin
            tick;
            if (!bad) begin
                checks++;
                if (dut_bus !== model(n)) begin
                    $display("FAIL mid_model n=%0d got %h expected %h", n, dut_bus, model(n));
                    errors++; bad = 1;
                end
            end
        end
        checks++;
        if ({H, V, CLK_7M, PHI0} !== {7'h63, 9'h150, 1'b1, 1'b1}) begin
            $display("FAIL mid_point got H=%h V=%h c7=%b phi=%b expected H=63 V=150 c7=1 phi=1",
                     H, V, CLK_7M, PHI0);
            errors++;
        end
        do_reset;
        checks++;
        if ({CLK_7M, PHI0, H, V, LDPS_N, WNDW_N} !== {1'b0, 1'b0, 7'h00, 9'h0FA, 1'b1, 1'b1}) begin
            $display("FAIL mid_reset got c7=%b phi=%b H=%h V=%h ld=%b w=%b expected 0 0 00 0fa 1 1",
                     CLK_7M, PHI0, H, V, LDPS_N, WNDW_N);
            errors++;
        end
        done = 0; prev_h = H;
        for (int i = 0; i < 2000 && !done; i++) begin
            tick;
            if (H == 7'h00 && prev_h == 7'h7F) done = 1;
            prev_h = H;
        end
        checks++;
        if (n !== LINE) begin
            $display("FAIL mid_realign got %0d expected %0d", n, LINE);
            errors++;
        end
    endtask

    task automatic test_frame_and_flash;
        int         seen [512];
        int         lines, wcyc, hs, vs, bad_v;
        logic       bad, first, s1, s2, s3;
        logic [6:0] fh;
        logic [8:0] fv;
        for (int i = 0; i < 512; i++) seen[i] = 0;
        lines = 0; wcyc = 0; hs = 0; vs = 0; bad = 0; first = 0; s1 = 0; s2 = 0; s3 = 0;
        fh = '0; fv = '0;
        do_reset;
        for (longint i = 0; i <= 2 * FRAME; i++) begin
            if (!bad) begin
                checks++;
                if (dut_bus !== model(n)) begin
                    $display("FAIL frame_model n=%0d got %h expected %h", n, dut_bus, model(n));
                    errors++; bad = 1;
                end
            end
            if (n < FRAME) begin
                if (CPU_EN && H == 7'h7F) begin seen[V]++; lines++; end
                if (CPU_EN && !WNDW_N) wcyc++;
                if (!WNDW_N && !first) begin first = 1; fh = H; fv = V; end
                if (HSYNC) hs++;
                if (VSYNC) vs++;
                if (V == 9'h105 && !s1) begin
                    s1 = 1; checks++;
                    if ({SEGC, SEGB, SEGA} !== 3'b101) begin
                        $display("FAIL seg_105 got %b expected 101", {SEGC, SEGB, SEGA});
                        errors++;
                    end
                end
                if (V == 9'h1BF && !s2) begin
                    s2 = 1; checks++;
                    if ({SEGC, SEGB, SEGA} !== 3'b111) begin
                        $display("FAIL seg_1bf got %b expected 111", {SEGC, SEGB, SEGA});
                        errors++;
                    end
                end
                if (V == 9'h1C0 && H == 7'h60 && !s3) begin
                    s3 = 1; checks++;
                    if ({VBL, WNDW_N} !== 2'b11) begin
                        $display("FAIL vbl_1c0 got vbl=%b w=%b expected 1 1", VBL, WNDW_N);
                        errors++;
                    end
                end
            end
            if (n == 2 * FRAME - 1) begin
                checks++;
                if (FLASH_CLK !== 1'b0) begin
                    $display("FAIL flash_before got %b expected 0", FLASH_CLK);
                    errors++;
                end
            end
            if (n == 2 * FRAME) begin
                checks++;
                if ({FLASH_CLK, H, V} !== {1'b1, 7'h00, 9'h0FA}) begin
                    $display("FAIL flash_edge got F=%b H=%h V=%h expected 1 00 0fa", FLASH_CLK, H, V);
                    errors++;
                end
            end else begin
                tick;
            end
        end
        bad_v = 0;
        for (int v = 0; v < 512; v++) begin
            if (seen[v] != ((v >= 250) ? 1 : 0)) bad_v++;
        end
        checks++;
        if (bad_v !== 0 || lines !== 262) begin
            $display("FAIL frame_lines got bad=%0d lines=%0d expected bad=0 lines=262", bad_v, lines);
            errors++;
        end
        checks++;
        if (wcyc !== 192 * 40) begin
            $display("FAIL window_cycles got %0d expected %0d", wcyc, 192 * 40);
            errors++;
        end
        checks++;
        if ({fh, fv} !== {7'h58, 9'h100}) begin
            $display("FAIL window_first got H=%h V=%h expected H=58 V=100", fh, fv);
            errors++;
        end
        checks++;
        if (hs !== 56 * 262) begin
            $display("FAIL hsync_clocks got %0d expected %0d", hs, 56 * 262);
            errors++;
        end
        checks++;
        if (vs !== 4 * 912) begin
            $display("FAIL vsync_clocks got %0d expected %0d", vs, 4 * 912);
            errors++;
        end
    endtask

    initial begin
        test_reset;
        test_line_timing;
        test_random_reset;
        test_midframe_reset;
        test_frame_and_flash;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
